fracnet_acc_requant: RTL and testbench

- Downstream consumer of the signed 16x12 DSP multiplier stage: takes its 28-bit signed product stream and produces one requantized 16-bit activation per group.
- Per group: sum cfg_len products plus a bias, round-shift right, saturate to 16 bits, emit with valid/ready.
- Sits between the multiplier array and the activation/binarization stage of the FracNet datapath.

---
 rtl/fracnet_acc_pkg.sv | 52 +++++
 rtl/fracnet_round_sat.sv | 22 ++
 rtl/fracnet_acc_requant.sv | 175 +++++++++++++++++
 tb/tb_fracnet_acc_requant.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fracnet_acc_pkg.sv
// Shared types, widths and the requantization helper for the FracNet
// accumulate/requantize stage and later requant stages.
package fracnet_acc_pkg;

  localparam int unsigned PROD_W  = 32'd28;
  localparam int unsigned ACC_W   = 32'd36;
  localparam int unsigned OUT_W   = 32'd16;
  localparam int unsigned CNT_W   = 32'd10;
  localparam int unsigned SHIFT_W = 32'd5;

  localparam logic [OUT_W-1:0] OUT_MAX = 16'h7FFF;  //  32767
  localparam logic [OUT_W-1:0] OUT_MIN = 16'h8000;  // -32768
  localparam logic [CNT_W-1:0] CNT_ONE = 10'd1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    FINISH = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  // Round-half-up arithmetic right shift followed by saturation to OUT_W.
  // Returns {sat, value}. The rounding add is done one bit wider than the
  // accumulator so the rounding constant can never overflow it.
  function automatic logic [OUT_W:0] round_shift_sat(
    input logic [ACC_W-1:0]   acc,
    input logic [SHIFT_W-1:0] shift
  );
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] shifted;
    logic                  sat;
    logic [OUT_W-1:0]      value;
    if (shift != {SHIFT_W{1'b0}}) begin
      rnd = $signed({{ACC_W{1'b0}}, 1'b1} << (shift - 5'd1));
    end else begin
      rnd = $signed({(ACC_W+1){1'b0}});
    end
    wide    = $signed({acc[ACC_W-1], acc}) + rnd;
    shifted = wide >>> shift;
    // In range when every bit from the output sign bit upward matches the sign.
    if (shifted[ACC_W:OUT_W-1] == {(ACC_W-OUT_W+2){shifted[ACC_W]}}) begin
      sat   = 1'b0;
      value = shifted[OUT_W-1:0];
    end else begin
      sat   = 1'b1;
      value = shifted[ACC_W] ? OUT_MIN : OUT_MAX;
    end
    return {sat, value};
  endfunction

endpackage

// File: rtl/fracnet_round_sat.sv
// Combinational ACC_W -> OUT_W rounding right shift with saturation.
// Reusable by any requant stage that needs the same rounding rule.
module fracnet_round_sat
  import fracnet_acc_pkg::*;
(
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   value,
  output logic               sat
);

  logic [OUT_W:0] res;

  // Evaluate the shared round/shift/saturate helper.
  always_comb begin
    res = round_shift_sat(acc, shift);
  end

  assign sat   = res[OUT_W];
  assign value = res[OUT_W-1:0];

endmodule

// File: rtl/fracnet_acc_requant.sv
// FracNet accumulate + requantize stage: sums cfg_len signed products plus a
// bias, round-shifts, saturates to 16 bits and emits one result per group.
// Optional build macro FRACNET_ACC_RELU_EN adds a per-group relu_en input
// that clamps negative (post-saturation) results to zero.
module fracnet_acc_requant
  import fracnet_acc_pkg::*;
(
  input  logic               ap_clk,
  input  logic               ap_rst,
  input  logic [CNT_W-1:0]   cfg_len,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [OUT_W-1:0]   bias,
`ifdef FRACNET_ACC_RELU_EN
  input  logic               relu_en,
`endif
  input  logic [PROD_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sat,
  output logic               busy
);

  state_t             state;
  state_t             next_state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;
  logic [SHIFT_W-1:0] shift_q;

  logic               in_xfer;
  logic [CNT_W-1:0]   len_eff;
  logic [CNT_W-1:0]   cnt_inc;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   bias_ext;
  logic [OUT_W-1:0]   rs_value;
  logic               rs_sat;
  logic [OUT_W-1:0]   res_final;

  assign in_xfer  = in_valid && in_ready;
  assign len_eff  = (cfg_len == {CNT_W{1'b0}}) ? CNT_ONE : cfg_len;
  assign cnt_inc  = cnt + CNT_ONE;
  assign prod_ext = {{(ACC_W-PROD_W){in_data[PROD_W-1]}}, in_data};
  assign bias_ext = {{(ACC_W-OUT_W){bias[OUT_W-1]}}, bias};

  fracnet_round_sat u_round_sat (
    .acc   (acc),
    .shift (shift_q),
    .value (rs_value),
    .sat   (rs_sat)
  );

`ifdef FRACNET_ACC_RELU_EN
  logic relu_q;

  // Capture the per-group clamp enable with the rest of the group config.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      relu_q <= 1'b0;
    end else if (state == IDLE && in_xfer) begin
      relu_q <= relu_en;
    end
  end

  // Clamp negatives to zero after saturation; out_sat is left as computed.
  always_comb begin
    if (relu_q && rs_value[OUT_W-1]) begin
      res_final = {OUT_W{1'b0}};
    end else begin
      res_final = rs_value;
    end
  end
`else
  assign res_final = rs_value;
`endif

  // Next-state logic: a group opens in IDLE, closes on its len_q-th product.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          next_state = (len_eff == CNT_ONE) ? FINISH : ACCUM;
        end else begin
          next_state = IDLE;
        end
      end
      ACCUM: begin
        if (in_xfer && (cnt_inc == len_q)) begin
          next_state = FINISH;
        end else begin
          next_state = ACCUM;
        end
      end
      FINISH:  next_state = OUTPUT;
      OUTPUT: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = OUTPUT;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State register plus registered in_ready/busy derived from the next state.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state == IDLE) || (next_state == ACCUM);
      busy     <= (next_state != IDLE);
    end
  end

  // Accumulator, counter and per-group config capture.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      acc     <= {ACC_W{1'b0}};
      cnt     <= {CNT_W{1'b0}};
      len_q   <= {CNT_W{1'b0}};
      shift_q <= {SHIFT_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            len_q   <= len_eff;
            shift_q <= cfg_shift;
            acc     <= bias_ext + prod_ext;
            cnt     <= CNT_ONE;
          end
        end
        ACCUM: begin
          if (in_xfer) begin
            acc <= acc + prod_ext;
            cnt <= cnt_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result register: loaded in FINISH, held until the downstream takes it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      out_valid <= 1'b0;
      out_data  <= {OUT_W{1'b0}};
      out_sat   <= 1'b0;
    end else begin
      case (state)
        FINISH: begin
          out_valid <= 1'b1;
          out_data  <= res_final;
          out_sat   <= rs_sat;
        end
        OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fracnet_acc_requant.sv
// Self-checking bench for fracnet_acc_requant: directed cases plus randomized
// groups, compared against a transaction-level arithmetic reference model.
module tb_fracnet_acc_requant;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  cfg_len;
  logic [4:0]  cfg_shift;
  logic [15:0] bias;
  logic [27:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sat;
  logic        busy;
`ifdef FRACNET_ACC_RELU_EN
  logic        relu_en;
`endif

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  // 0: always ready, 1: random ready, 2: manual ready
  int   rdy_mode = 0;
  logic manual_ready = 1'b0;

  // Reference model state
  bit     in_grp = 1'b0;
  int     g_len, g_sh, g_cnt;
  bit     g_relu;
  longint g_sum;
  int     last_cyc = 0;
  bit     prev_valid = 1'b0;
  longint exp_d[$];
  bit     exp_s[$];

  fracnet_acc_requant dut (
    .ap_clk    (clk),
    .ap_rst    (rst),
    .cfg_len   (cfg_len),
    .cfg_shift (cfg_shift),
    .bias      (bias),
`ifdef FRACNET_ACC_RELU_EN
    .relu_en   (relu_en),
`endif
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected result from plain arithmetic: wrap to 36 bits, round half up,
  // arithmetic shift, clip to int16, optional relu.
  task automatic ref_result(input longint s, input int sh, input bit relu,
                            output longint v, output bit sat);
    longint w;
    longint r;
    w = (s <<< 28) >>> 28;
    if (sh > 0) r = (w + (longint'(1) <<< (sh - 1))) >>> sh;
    else        r = w;
    sat = (r > 32767) || (r < -32768);
    if (r > 32767)       v = 32767;
    else if (r < -32768) v = -32768;
    else                 v = r;
    if (relu && v < 0) v = 0;
  endtask

  // Downstream ready generator.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = (($urandom % 4) != 0);
    else                    out_ready = manual_ready;
  end

  // Monitor + reference model, sampled mid-cycle.
  always @(negedge clk) begin
    longint v;
    bit     s;
    if (rst) begin
      in_grp     = 1'b0;
      prev_valid = 1'b0;
      exp_d.delete();
      exp_s.delete();
    end else begin
      if (in_valid && in_ready) begin
        if (!in_grp) begin
          in_grp = 1'b1;
          g_len  = (cfg_len == 10'd0) ? 1 : int'(cfg_len);
          g_sh   = int'(cfg_shift);
          g_sum  = longint'($signed(bias));
          g_cnt  = 0;
`ifdef FRACNET_ACC_RELU_EN
          g_relu = relu_en;
`else
          g_relu = 1'b0;
`endif
        end
        g_sum = g_sum + longint'($signed(in_data));
        g_cnt++;
        if (g_cnt == g_len) begin
          ref_result(g_sum, g_sh, g_relu, v, s);
          exp_d.push_back(v);
          exp_s.push_back(s);
          in_grp   = 1'b0;
          last_cyc = cyc;
        end
      end
      if (out_valid) begin
        chk("in_ready_low_in_output", longint'(in_ready), 0);
        if (!prev_valid) chk("latency", longint'(cyc - last_cyc), 2);
        if (exp_d.size() == 0) begin
          chk("spurious_output", longint'(out_valid), 0);
        end else begin
          chk("out_data", longint'($signed(out_data)), exp_d[0]);
          chk("out_sat", longint'(out_sat), longint'(exp_s[0]));
          if (out_ready) begin
            void'(exp_d.pop_front());
            void'(exp_s.pop_front());
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  // Offer one product and hold it until accepted.
  task automatic push(input logic [27:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready && !rst) break;
      n++;
      if (n > 500) begin
        errors++;
        $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles", n);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait until every expected result has been delivered and the block is idle.
  task automatic drain();
    int n;
    n = 0;
    while ((exp_d.size() != 0 || busy || in_grp) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding", exp_d.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input int len, input int sh, input int b);
    cfg_len   = 10'(len);
    cfg_shift = 5'(sh);
    bias      = 16'(b);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 28'd0;
    set_cfg(0, 0, 0);
`ifdef FRACNET_ACC_RELU_EN
    relu_en = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_data", longint'(out_data), 0);
    chk("rst_out_sat", longint'(out_sat), 0);
    chk("rst_busy", longint'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_first_cycle", longint'(in_ready), 0);
    @(negedge clk);
    chk("in_ready_after_reset", longint'(in_ready), 1);
    @(posedge clk); #1;

    // Basic sum with bias.
    set_cfg(4, 0, 10);
    push(28'd100); push(-28'sd50); push(28'd25); push(28'd5);
    drain();

    // Rounding half up, both signs.
    set_cfg(1, 4, 0);
    push(28'd24);
    push(-28'sd24);
    drain();

    // Saturation at both rails.
    set_cfg(2, 0, 0);
    push(28'h7FFFFFF); push(28'h7FFFFFF);
    push(28'h8000000); push(28'h8000000);
    drain();

    // Output backpressure: hold for 5 cycles, then a single ready cycle.
    rdy_mode = 2; manual_ready = 1'b0;
    @(posedge clk); #1;
    set_cfg(1, 0, 0);
    push(28'd7);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("bp_valid_seen", longint'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_data_hold", longint'($signed(out_data)), 7);
      chk("bp_in_ready", longint'(in_ready), 0);
    end
    @(posedge clk); manual_ready = 1'b1;
    @(posedge clk); manual_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", longint'(in_ready), 1);
    chk("bp_valid_cleared", longint'(out_valid), 0);
    rdy_mode = 0;
    drain();

    // cfg_len 0 behaves as 1.
    set_cfg(0, 0, 3);
    push(28'd1); push(28'd2); push(28'd3);
    drain();

    // Mid-group cfg change ignored.
    set_cfg(3, 0, 0);
    push(28'd11);
    set_cfg(8, 3, 100);
    push(28'd12); push(28'd13);
    drain();
    chk("midgroup_idle", longint'(busy), 0);

    // Reset mid-group.
    set_cfg(4, 0, 0);
    push(28'd9); push(28'd9);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", longint'(busy), 0);
    chk("rst_mid_out_valid", longint'(out_valid), 0);
    @(posedge clk); #1;
    set_cfg(4, 0, 0);
    push(28'd1); push(28'd1); push(28'd1); push(28'd1);
    drain();

    // Randomized groups with random backpressure and mid-group cfg churn.
    rdy_mode = 1;
    for (int g = 0; g < 40; g++) begin
      int len;
      int np;
      len = $urandom_range(0, 6);
      np  = (len == 0) ? 1 : len;
      set_cfg(len, $urandom_range(0, 31), $urandom);
`ifdef FRACNET_ACC_RELU_EN
      relu_en = 1'($urandom);
`endif
      for (int k = 0; k < np; k++) begin
        push(28'($urandom));
        if (k == 0) set_cfg($urandom_range(0, 1023), $urandom_range(0, 31), $urandom);
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
